bus_timer: RTL and testbench

Memory-mapped 32-bit interval timer that acts as a responder on the shared CPU bus. It answers the bus master's active-low address-strobe transactions with a registered `rdy_n` and `rd_data` one cycle later. It exposes four word registers: control, interrupt, expiry value and counter. It raises a level interrupt to the CPU when the counter reaches the expiry value. It is the slave-side counterpart of the CPU bus interface, attached through the bus decoder's chip select.

---
 rtl/bus_timer.sv | 114 +++++++++++
 tb/tb_bus_timer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 32-bit interval timer responding on the CPU bus.
// Four word registers: CTRL, INTR, EXPR, COUNTER; level irq on expiry.
module bus_timer #(
    parameter logic [31:0] EXPR_RST = 32'h0000_0000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        cs_n,
    input  logic        as_n,
    input  logic        rw,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_n,
    output logic        irq
);

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_INTR = 2'd1;
    localparam logic [1:0] A_EXPR = 2'd2;
    localparam logic [1:0] A_CNT  = 2'd3;

    logic        start_q, start_d;
    logic        per_q, per_d;
    logic        intr_q, intr_d;
    logic [31:0] expr_q, expr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdy_n_q, rdy_n_d;

    logic        acc;
    logic        wr;
    logic        match;
    logic [31:0] rmux;

    assign acc   = !cs_n && !as_n;
    assign wr    = acc && !rw;
    assign match = start_q && (cnt_q == expr_q);

    // Read mux over the pre-update register values
    always_comb begin
        rmux = 32'h0;
        unique case (addr)
            A_CTRL:  rmux = {30'h0, per_q, start_q};
            A_INTR:  rmux = {31'h0, intr_q};
            A_EXPR:  rmux = expr_q;
            A_CNT:   rmux = cnt_q;
            default: rmux = 32'h0;
        endcase
    end

    // Next state: counting, then bus writes, then expiry forces the flag
    always_comb begin
        start_d = start_q;
        per_d   = per_q;
        intr_d  = intr_q;
        expr_d  = expr_q;
        cnt_d   = cnt_q;
        if (start_q) begin
            if (match) begin
                cnt_d = 32'h0;
                if (!per_q) begin
                    start_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
        if (wr) begin
            unique case (addr)
                A_CTRL: begin
                    start_d = wr_data[0];
                    per_d   = wr_data[1];
                end
                A_INTR:  intr_d = wr_data[0];
                A_EXPR:  expr_d = wr_data;
                A_CNT:   cnt_d  = wr_data;
                default: ;
            endcase
        end
        // An expiry must never be lost to a same-edge software clear
        if (match) begin
            intr_d = 1'b1;
        end
        rdy_n_d = !acc;
        rdata_d = (acc && rw) ? rmux : 32'h0;
    end

    // State and registered bus response
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            start_q <= 1'b0;
            per_q   <= 1'b0;
            intr_q  <= 1'b0;
            expr_q  <= EXPR_RST;
            cnt_q   <= 32'h0;
            rdata_q <= 32'h0;
            rdy_n_q <= 1'b1;
        end else begin
            start_q <= start_d;
            per_q   <= per_d;
            intr_q  <= intr_d;
            expr_q  <= expr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rdy_n_q <= rdy_n_d;
        end
    end

    assign rd_data = rdata_q;
    assign rdy_n   = rdy_n_q;
    assign irq     = intr_q;

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed vector table plus hand-written timing sequences
// for the bus_timer responder.
module tb_bus_timer;

    localparam logic [31:0] RSTV = 32'hA5A5_0001;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic        cs_n;
    logic        as_n;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_n;
    logic        irq;

    int n_run;
    int n_fail;

    bus_timer #(.EXPR_RST(RSTV)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rstn(cpu_rstn),
        .cs_n    (cs_n),
        .as_n    (as_n),
        .rw      (rw),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .rdy_n   (rdy_n),
        .irq     (irq)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic        rw;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        irq;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a falling edge; one accept edge, then one idle cycle.
    task automatic access(input logic r, input logic [1:0] a,
                          input logic [31:0] wd, input logic [31:0] exp,
                          input string nm, output logic irq_r);
        cs_n    = 1'b0;
        as_n    = 1'b0;
        rw      = r;
        addr    = a;
        wr_data = wd;
        @(negedge cpu_clk);
        check({nm, " rdy"}, {31'h0, rdy_n}, 32'h0);
        check({nm, " data"}, rd_data, exp);
        irq_r   = irq;
        cs_n    = 1'b1;
        as_n    = 1'b1;
        rw      = 1'b1;
        wr_data = 32'h0;
        @(negedge cpu_clk);
        check({nm, " idle rdy"}, {31'h0, rdy_n}, 32'h1);
        check({nm, " idle data"}, rd_data, 32'h0);
    endtask

    vec_t vt[17];
    logic ir;

    initial begin
        n_run    = 0;
        n_fail   = 0;
        cpu_rstn = 1'b0;
        cs_n     = 1'b1;
        as_n     = 1'b1;
        rw       = 1'b1;
        addr     = 2'd0;
        wr_data  = 32'h0;

        vt[0]  = '{1'b1, 2'd0, 32'h0, 32'h0, 1'b0};
        vt[1]  = '{1'b1, 2'd1, 32'h0, 32'h0, 1'b0};
        vt[2]  = '{1'b1, 2'd2, 32'h0, RSTV, 1'b0};
        vt[3]  = '{1'b1, 2'd3, 32'h0, 32'h0, 1'b0};
        vt[4]  = '{1'b0, 2'd2, 32'h5, 32'h0, 1'b0};
        vt[5]  = '{1'b1, 2'd2, 32'h0, 32'h5, 1'b0};
        vt[6]  = '{1'b0, 2'd0, 32'hFFFF_FFFE, 32'h0, 1'b0};
        vt[7]  = '{1'b1, 2'd0, 32'h0, 32'h2, 1'b0};
        vt[8]  = '{1'b0, 2'd0, 32'h0, 32'h0, 1'b0};
        vt[9]  = '{1'b1, 2'd0, 32'h0, 32'h0, 1'b0};
        vt[10] = '{1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vt[11] = '{1'b1, 2'd1, 32'h0, 32'h1, 1'b1};
        vt[12] = '{1'b0, 2'd1, 32'h0, 32'h0, 1'b0};
        vt[13] = '{1'b1, 2'd1, 32'h0, 32'h0, 1'b0};
        vt[14] = '{1'b0, 2'd3, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vt[15] = '{1'b1, 2'd3, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vt[16] = '{1'b0, 2'd3, 32'h0, 32'h0, 1'b0};

        repeat (2) @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        @(negedge cpu_clk);

        // Dirty the state, then reset in the middle of a read response
        access(1'b0, 2'd2, 32'h1234, 32'h0, "pre expr", ir);
        access(1'b0, 2'd1, 32'h1, 32'h0, "pre intr", ir);
        access(1'b0, 2'd3, 32'h7, 32'h0, "pre cnt", ir);
        cs_n = 1'b0;
        as_n = 1'b0;
        rw   = 1'b1;
        addr = 2'd2;
        @(posedge cpu_clk);
        #1 cpu_rstn = 1'b0;
        #1;
        check("rst rdy", {31'h0, rdy_n}, 32'h1);
        check("rst data", rd_data, 32'h0);
        check("rst irq", {31'h0, irq}, 32'h0);
        cs_n = 1'b1;
        as_n = 1'b1;
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        @(negedge cpu_clk);
        check("rst drop rdy", {31'h0, rdy_n}, 32'h1);

        // Register map round trips
        for (int i = 0; i < 17; i++) begin
            access(vt[i].rw, vt[i].addr, vt[i].wd, vt[i].exp,
                   $sformatf("vec%0d", i), ir);
            check($sformatf("vec%0d irq", i), {31'h0, ir},
                  {31'h0, vt[i].irq});
        end

        // One-shot, EXPR=3: irq after the 4th edge past the CTRL write
        access(1'b0, 2'd2, 32'h3, 32'h0, "os expr", ir);
        access(1'b0, 2'd0, 32'h1, 32'h0, "os ctrl", ir);
        for (int i = 2; i <= 5; i++) begin
            @(negedge cpu_clk);
            check($sformatf("os irq e%0d", i), {31'h0, irq},
                  (i >= 4) ? 32'h1 : 32'h0);
        end
        access(1'b1, 2'd0, 32'h0, 32'h0, "os ctrl rd", ir);
        access(1'b1, 2'd3, 32'h0, 32'h0, "os cnt rd", ir);
        repeat (3) @(negedge cpu_clk);
        access(1'b1, 2'd3, 32'h0, 32'h0, "os cnt hold", ir);
        access(1'b0, 2'd1, 32'h0, 32'h0, "os clr", ir);

        // Periodic, EXPR=2: expiries at T+3, T+6, T+9
        access(1'b0, 2'd2, 32'h2, 32'h0, "per expr", ir);
        access(1'b0, 2'd0, 32'h3, 32'h0, "per ctrl", ir);
        @(negedge cpu_clk);
        check("per irq t2", {31'h0, irq}, 32'h0);
        @(negedge cpu_clk);
        check("per irq t3", {31'h0, irq}, 32'h1);
        access(1'b0, 2'd1, 32'h0, 32'h0, "per clr4", ir);
        check("per irq t4", {31'h0, ir}, 32'h0);
        check("per irq t5", {31'h0, irq}, 32'h0);
        access(1'b0, 2'd1, 32'h0, 32'h0, "per race6", ir);
        check("per race irq", {31'h0, ir}, 32'h1);
        check("per irq t7", {31'h0, irq}, 32'h1);
        access(1'b0, 2'd1, 32'h0, 32'h0, "per clr8", ir);
        check("per clr8 irq", {31'h0, ir}, 32'h0);
        check("per irq t9", {31'h0, irq}, 32'h1);

        // Counter write beats hardware clear, then wrap without irq
        access(1'b0, 2'd0, 32'h0, 32'h0, "wr stop", ir);
        access(1'b0, 2'd1, 32'h0, 32'h0, "wr iclr", ir);
        access(1'b0, 2'd2, 32'h1, 32'h0, "wr expr", ir);
        access(1'b0, 2'd3, 32'h0, 32'h0, "wr cnt0", ir);
        access(1'b0, 2'd0, 32'h3, 32'h0, "wr ctrl", ir);
        access(1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0, "wr cnt", ir);
        check("wr hit irq", {31'h0, ir}, 32'h1);
        access(1'b0, 2'd1, 32'h0, 32'h0, "wr wrap clr", ir);
        check("wrap irq t4", {31'h0, ir}, 32'h0);
        check("wrap irq t5", {31'h0, irq}, 32'h0);
        @(negedge cpu_clk);
        check("wrap irq t6", {31'h0, irq}, 32'h1);

        // CTRL write on the one-shot expiry edge keeps start
        access(1'b0, 2'd0, 32'h0, 32'h0, "cc stop", ir);
        access(1'b0, 2'd3, 32'h0, 32'h0, "cc cnt0", ir);
        access(1'b0, 2'd1, 32'h0, 32'h0, "cc iclr", ir);
        access(1'b0, 2'd0, 32'h1, 32'h0, "cc go", ir);
        access(1'b0, 2'd0, 32'h1, 32'h0, "cc race", ir);
        check("cc irq", {31'h0, ir}, 32'h1);
        access(1'b1, 2'd0, 32'h0, 32'h1, "cc ctrl rd", ir);
        access(1'b0, 2'd0, 32'h0, 32'h0, "cc stop2", ir);

        // Chip-select gating
        cs_n    = 1'b1;
        as_n    = 1'b0;
        rw      = 1'b0;
        addr    = 2'd2;
        wr_data = 32'h55;
        @(negedge cpu_clk);
        check("cs rdy a", {31'h0, rdy_n}, 32'h1);
        @(negedge cpu_clk);
        check("cs rdy b", {31'h0, rdy_n}, 32'h1);
        as_n    = 1'b1;
        rw      = 1'b1;
        wr_data = 32'h0;
        access(1'b1, 2'd2, 32'h0, 32'h1, "cs expr rd", ir);

        // Strobe held for two edges gives two responses
        cs_n = 1'b0;
        as_n = 1'b0;
        rw   = 1'b1;
        addr = 2'd2;
        @(negedge cpu_clk);
        check("hold rdy1", {31'h0, rdy_n}, 32'h0);
        check("hold data1", rd_data, 32'h1);
        @(negedge cpu_clk);
        check("hold rdy2", {31'h0, rdy_n}, 32'h0);
        check("hold data2", rd_data, 32'h1);
        cs_n = 1'b1;
        as_n = 1'b1;
        @(negedge cpu_clk);
        check("hold rdy3", {31'h0, rdy_n}, 32'h1);
        check("hold data3", rd_data, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
